// File: rtl/dvi_output_sequencer.sv
// DVI output start-up / run-time sequencer.
// Keeps the VGA timing generator in reset and the TMDS lanes dark until the
// pixel PLL has locked and settled, enables the lanes on a frame boundary,
// and steps the test pattern on vsync after a debounced button press.
module dvi_output_sequencer #(
  parameter int   C_settle_cycles   = 65536,
  parameter int   C_debounce_cycles = 250000,
  parameter int   C_patterns        = 4,
  parameter logic C_vsync_active    = 1'b1
) (
  input  logic                          clk_pixel,
  input  logic                          reset,
  input  logic                          clk_locked,
  input  logic                          btn,
  input  logic                          vga_vsync,
  output logic                          timing_reset,
  output logic                          tmds_enable,
  output logic [$clog2(C_patterns)-1:0] pattern_sel,
  output logic [15:0]                   frame_count,
  output logic [2:0]                    state_o
);

  localparam int PAT_W = $clog2(C_patterns);
  localparam int SET_W = $clog2(C_settle_cycles);
  localparam int DB_W  = $clog2(C_debounce_cycles);

  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(C_settle_cycles - 1);
  localparam logic [DB_W-1:0]  DB_LAST     = DB_W'(C_debounce_cycles - 1);
  localparam logic [PAT_W-1:0] PAT_LAST    = PAT_W'(C_patterns - 1);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    SETTLE    = 3'd1,
    START     = 3'd2,
    SYNC      = 3'd3,
    RUN       = 3'd4
  } state_t;

  state_t           state;
  state_t           next_state;
  logic             lock_meta;
  logic             lock_s;
  logic             btn_meta;
  logic             btn_s;
  logic             vsync_prev;
  logic             vsync_edge;
  logic             lock_lost;
  logic [SET_W-1:0] settle_cnt;
  logic [DB_W-1:0]  db_cnt;
  logic             btn_db;
  logic             db_rise;
  logic             pending;
  logic             advance;

  assign vsync_edge = (vga_vsync == C_vsync_active) && (vsync_prev != C_vsync_active);
  assign lock_lost  = (state != WAIT_LOCK) && !lock_s;
  assign db_rise    = btn_s && !btn_db && (db_cnt == DB_LAST);
  assign advance    = (state == RUN) && vsync_edge && pending && !lock_lost;
  assign state_o    = state;

  // Two-flop synchronisers for the asynchronous lock and button inputs, plus vsync history
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      lock_meta  <= 1'b0;
      lock_s     <= 1'b0;
      btn_meta   <= 1'b0;
      btn_s      <= 1'b0;
      vsync_prev <= C_vsync_active;
    end else begin
      lock_meta  <= clk_locked;
      lock_s     <= lock_meta;
      btn_meta   <= btn;
      btn_s      <= btn_meta;
      vsync_prev <= vga_vsync;
    end
  end

  // FSM state register
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      state <= WAIT_LOCK;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic; losing lock overrides every other transition
  always_comb begin
    next_state = state;
    if (lock_lost) begin
      next_state = WAIT_LOCK;
    end else begin
      case (state)
        WAIT_LOCK: if (lock_s) next_state = SETTLE;
        SETTLE:    if (settle_cnt == '0) next_state = START;
        START:     next_state = SYNC;
        SYNC:      if (vsync_edge) next_state = RUN;
        RUN:       next_state = RUN;
        default:   next_state = WAIT_LOCK;
      endcase
    end
  end

  // Settle counter: loaded on SETTLE entry, counts down to zero while settling
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      settle_cnt <= '0;
    end else if ((next_state == SETTLE) && (state != SETTLE)) begin
      settle_cnt <= SETTLE_LOAD;
    end else if ((state == SETTLE) && (settle_cnt != '0)) begin
      settle_cnt <= settle_cnt - SET_W'(1);
    end
  end

  // Registered path controls; timing release lands the cycle after START is entered,
  // while lock loss reasserts reset and darkens the lanes together with the state change
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      timing_reset <= 1'b1;
      tmds_enable  <= 1'b0;
    end else begin
      timing_reset <= (state == WAIT_LOCK) || (state == SETTLE) || (next_state == WAIT_LOCK);
      tmds_enable  <= (next_state == RUN);
    end
  end

  // Button debounce: accept a new level only after it has been held for the full window
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      db_cnt <= '0;
      btn_db <= 1'b0;
    end else if (btn_s == btn_db) begin
      db_cnt <= '0;
    end else if (db_cnt == DB_LAST) begin
      db_cnt <= '0;
      btn_db <= btn_s;
    end else begin
      db_cnt <= db_cnt + DB_W'(1);
    end
  end

  // Pending pattern request; a new press on the consuming vsync edge survives to the next frame
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      pending <= 1'b0;
    end else if (lock_lost) begin
      pending <= 1'b0;
    end else if (db_rise) begin
      pending <= 1'b1;
    end else if (advance) begin
      pending <= 1'b0;
    end
  end

  // Test pattern index, stepped on a vsync edge in RUN and kept across lock loss
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      pattern_sel <= '0;
    end else if (advance) begin
      pattern_sel <= (pattern_sel == PAT_LAST) ? '0 : pattern_sel + PAT_W'(1);
    end
  end

  // Frame counter: counts vsync edges seen in RUN, cleared when lock is lost
  always_ff @(posedge clk_pixel) begin
    if (reset) begin
      frame_count <= '0;
    end else if (lock_lost) begin
      frame_count <= '0;
    end else if ((state == RUN) && vsync_edge) begin
      frame_count <= frame_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_dvi_output_sequencer.sv
// Scoreboard bench for dvi_output_sequencer: directed stimulus queues expected
// output values tagged with the cycle they must appear; a monitor on the falling
// clock edge pops and compares them.
module tb_dvi_output_sequencer;

  localparam int F_STATE = 0;
  localparam int F_TR    = 1;
  localparam int F_TMDS  = 2;
  localparam int F_PAT   = 3;
  localparam int F_FC    = 4;

  logic        clk_pixel;
  logic        reset;
  logic        clk_locked;
  logic        btn;
  logic        vga_vsync;
  logic        timing_reset;
  logic        tmds_enable;
  logic [1:0]  pattern_sel;
  logic [15:0] frame_count;
  logic [2:0]  state_o;

  typedef struct {
    int f;
    int val;
    int at;
  } exp_t;

  exp_t sb[$];
  int   cyc      = 0;
  int   n_checks = 0;
  int   n_fail   = 0;

  dvi_output_sequencer #(
    .C_settle_cycles  (16),
    .C_debounce_cycles(8),
    .C_patterns       (3),
    .C_vsync_active   (1'b1)
  ) dut (
    .clk_pixel   (clk_pixel),
    .reset       (reset),
    .clk_locked  (clk_locked),
    .btn         (btn),
    .vga_vsync   (vga_vsync),
    .timing_reset(timing_reset),
    .tmds_enable (tmds_enable),
    .pattern_sel (pattern_sel),
    .frame_count (frame_count),
    .state_o     (state_o)
  );

  initial clk_pixel = 1'b0;
  always #5 clk_pixel = ~clk_pixel;

  always @(posedge clk_pixel) cyc <= cyc + 1;

  function automatic int actual(int f);
    case (f)
      F_STATE: return int'(state_o);
      F_TR:    return int'(timing_reset);
      F_TMDS:  return int'(tmds_enable);
      F_PAT:   return int'(pattern_sel);
      default: return int'(frame_count);
    endcase
  endfunction

  function automatic string fname(int f);
    case (f)
      F_STATE: return "state_o";
      F_TR:    return "timing_reset";
      F_TMDS:  return "tmds_enable";
      F_PAT:   return "pattern_sel";
      default: return "frame_count";
    endcase
  endfunction

  // Monitor: compare every expectation that falls due in this cycle
  exp_t e;
  int   act;
  always @(negedge clk_pixel) begin
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e   = sb.pop_front();
      act = actual(e.f);
      n_checks++;
      if (act != e.val) begin
        n_fail++;
        $display("FAIL %s cyc %0d: got %0d expected %0d", fname(e.f), cyc, act, e.val);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk_pixel);
      #2;
    end
  endtask

  // Queue an expectation d cycles from now, keeping the queue ordered by due cycle
  task automatic expect_at(input int f, input int v, input int d);
    exp_t x;
    int   i;
    x.f   = f;
    x.val = v;
    x.at  = cyc + d;
    i = sb.size();
    while (i > 0 && sb[i-1].at > x.at) i--;
    sb.insert(i, x);
  endtask

  task automatic press(input int n);
    btn = 1'b1;
    tick(n);
    btn = 1'b0;
    tick(14);
  endtask

  // Raise lock from WAIT_LOCK and run through SETTLE/START into SYNC
  task automatic lock_up();
    clk_locked = 1'b1;
    expect_at(F_STATE, 0, 2);
    expect_at(F_STATE, 1, 3);
    expect_at(F_TR,    1, 10);
    expect_at(F_STATE, 1, 18);
    expect_at(F_STATE, 2, 19);
    expect_at(F_TR,    1, 19);
    expect_at(F_STATE, 3, 20);
    expect_at(F_TR,    0, 20);
    expect_at(F_TMDS,  0, 20);
    tick(30);
    expect_at(F_TMDS,  0, 0);
  endtask

  // First vsync edge in SYNC: enter RUN with the lanes on
  task automatic enter_run(input int pat);
    expect_at(F_STATE, 3, 0);
    vga_vsync = 1'b1;
    expect_at(F_STATE, 4, 1);
    expect_at(F_TMDS,  1, 1);
    expect_at(F_TR,    0, 1);
    expect_at(F_FC,    0, 1);
    expect_at(F_PAT,   pat, 1);
    tick(4);
    vga_vsync = 1'b0;
    tick(20);
  endtask

  task automatic frame(input int pat, input int fc);
    vga_vsync = 1'b1;
    expect_at(F_STATE, 4,   1);
    expect_at(F_PAT,   pat, 1);
    expect_at(F_FC,    fc,  1);
    tick(4);
    vga_vsync = 1'b0;
    tick(30);
  endtask

  task automatic drop_lock(input int from_state, input int pat);
    clk_locked = 1'b0;
    expect_at(F_STATE, from_state, 2);
    expect_at(F_STATE, 0,   3);
    expect_at(F_TR,    1,   3);
    expect_at(F_TMDS,  0,   3);
    expect_at(F_FC,    0,   3);
    expect_at(F_PAT,   pat, 3);
    tick(8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset      = 1'b1;
    clk_locked = 1'b0;
    btn        = 1'b0;
    vga_vsync  = 1'b0;
    tick(3);
    expect_at(F_STATE, 0, 0);
    expect_at(F_TR,    1, 0);
    expect_at(F_TMDS,  0, 0);
    expect_at(F_PAT,   0, 0);
    expect_at(F_FC,    0, 0);
    tick(1);
    reset = 1'b0;
    tick(4);

    // Bring-up and first frame boundary
    lock_up();
    enter_run(0);

    // Single press, then three presses across three frames
    press(8);
    frame(1, 1);
    press(8);
    frame(2, 2);
    press(8);
    frame(0, 3);
    press(8);
    frame(1, 4);

    // Glitches shorter than the debounce window
    for (int n = 3; n <= 7; n++) press(n);
    frame(1, 5);

    // Two presses within one frame advance once
    press(8);
    press(8);
    frame(2, 6);
    frame(2, 7);

    // Debounced press landing on the vsync edge waits for the next frame
    btn = 1'b1;
    tick(8);
    btn = 1'b0;
    tick(1);
    vga_vsync = 1'b1;
    expect_at(F_PAT, 2, 1);
    expect_at(F_FC,  8, 1);
    tick(4);
    vga_vsync = 1'b0;
    tick(20);
    frame(0, 9);

    // Frame counter wrap
    force dut.frame_count = 16'hFFFF;
    tick(1);
    release dut.frame_count;
    tick(2);
    expect_at(F_FC, 16'hFFFF, 0);
    tick(1);
    frame(0, 0);

    // Lock loss in RUN with a request pending: pattern kept, request dropped
    press(8);
    frame(1, 1);
    press(8);
    drop_lock(4, 1);
    lock_up();
    enter_run(1);
    frame(1, 1);

    // Lock loss in RUN, then again part way through SETTLE
    drop_lock(4, 1);
    clk_locked = 1'b1;
    tick(8);
    expect_at(F_STATE, 1, 0);
    expect_at(F_TR,    1, 0);
    drop_lock(1, 1);

    // Press while in SYNC is applied at the first vsync edge seen in RUN
    lock_up();
    press(8);
    enter_run(1);
    frame(2, 1);

    // Reset in RUN
    reset = 1'b1;
    expect_at(F_STATE, 0, 1);
    expect_at(F_TR,    1, 1);
    expect_at(F_TMDS,  0, 1);
    expect_at(F_PAT,   0, 1);
    expect_at(F_FC,    0, 1);
    tick(2);
    reset = 1'b0;
    tick(3);

    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
